// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared state encoding and sum-width helper for the accumulator feeder
package acc_pkg;

  typedef enum logic [2:0] {
    ST_FILL  = 3'd0,
    ST_READY = 3'd1,
    ST_START = 3'd2,
    ST_LEAD  = 3'd3,
    ST_SEND  = 3'd4,
    ST_WAIT  = 3'd5
  } acc_state_e;

  function automatic int sum_w(input int width, input int len);
    return width + $clog2(len);
  endfunction

endpackage

// File: rtl/acc_feeder_if.sv
// rtl/acc_feeder_if.sv - job bus between the feeder (master) and the accumulator (slave)
interface acc_feeder_if #(
  parameter int WIDTH = 32,
  parameter int SW    = 36
);
  logic             acc_start;
  logic             acc_data_rdy;
  logic [WIDTH-1:0] acc_indata;
  logic [SW-1:0]    acc_outdata;
  logic             acc_cal_done;

  modport master (
    output acc_start, acc_data_rdy, acc_indata,
    input  acc_outdata, acc_cal_done
  );

  modport slave (
    input  acc_start, acc_data_rdy, acc_indata,
    output acc_outdata, acc_cal_done
  );
endinterface

// File: rtl/acc_feed_buf.sv
// rtl/acc_feed_buf.sv - LEN x WIDTH word buffer, synchronous write port, registered read port
module acc_feed_buf #(
  parameter int WIDTH = 32,
  parameter int LEN   = 16,
  parameter int IW    = $clog2(LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [IW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [IW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);
  logic [WIDTH-1:0] mem_q [LEN];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Read register only loads on a beat, so the word stays put across gap cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/acc_feeder.sv
// rtl/acc_feeder.sv - buffers LEN words, replays them as one accumulate job, checks the returned sum
module acc_feeder
  import acc_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LEN     = 16,
  parameter int GAP     = 0,
  parameter int TIMEOUT = 255,
  localparam int SW     = sum_w(WIDTH, LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             go_i,
  output logic             busy_o,
  acc_feeder_if.master     acc,
  output logic [SW-1:0]    result_o,
  output logic             result_valid_o,
  output logic             match_o,
  output logic             timeout_err_o,
  output logic             proto_err_o
);
  localparam int AW = $clog2(LEN + 1);
  localparam int IW = $clog2(LEN);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  acc_state_e    state_q, state_d;
  logic [AW-1:0] count_q, count_d, idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic [SW-1:0] exp_sum_q, exp_sum_d, result_q, result_d;
  logic          in_ready_q, busy_q, start_q, data_rdy_q, result_valid_q, match_q;
  logic          timeout_q, proto_q;
  logic          result_valid_d, match_d, timeout_d, proto_d;
  logic          xfer, rd_en;
  logic [WIDTH-1:0] rd_data;

  acc_feed_buf #(.WIDTH(WIDTH), .LEN(LEN), .IW(IW)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (xfer),
    .wr_addr_i (count_q[IW-1:0]),
    .wr_data_i (in_data_i),
    .rd_en_i   (rd_en),
    .rd_addr_i (idx_q[IW-1:0]),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    idx_d          = idx_q;
    gap_d          = gap_q;
    wcnt_d         = wcnt_q;
    exp_sum_d      = exp_sum_q;
    result_d       = result_q;
    match_d        = match_q;
    timeout_d      = timeout_q;
    proto_d        = proto_q;
    result_valid_d = 1'b0;
    rd_en          = 1'b0;
    xfer           = 1'b0;

    unique case (state_q)
      ST_FILL: begin
        xfer = in_valid_i & in_ready_q;
        if (xfer) begin
          count_d   = count_q + 1'b1;
          exp_sum_d = exp_sum_q + SW'(in_data_i);
          if (count_d == AW'(LEN)) state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (go_i) begin
          state_d   = ST_START;
          idx_d     = '0;
          timeout_d = 1'b0;
          proto_d   = 1'b0;
        end
      end
      ST_START: state_d = ST_LEAD;
      // The read issued here lands on the outputs at start+2.
      ST_LEAD: begin
        state_d = ST_SEND;
        rd_en   = 1'b1;
        idx_d   = idx_q + 1'b1;
        gap_d   = '0;
      end
      ST_SEND: begin
        if (data_rdy_q && idx_q == AW'(LEN)) begin
          state_d = ST_WAIT;
          wcnt_d  = '0;
        end else if (gap_q == GW'(GAP)) begin
          rd_en = 1'b1;
          idx_d = idx_q + 1'b1;
          gap_d = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (acc.acc_cal_done) begin
          result_d       = acc.acc_outdata;
          match_d        = (acc.acc_outdata == exp_sum_q);
          result_valid_d = 1'b1;
          state_d        = ST_FILL;
        end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          match_d   = 1'b0;
          state_d   = ST_FILL;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
        if (state_d == ST_FILL) begin
          count_d   = '0;
          exp_sum_d = '0;
        end
      end
      default: state_d = ST_FILL;
    endcase

    if (acc.acc_cal_done && state_q != ST_WAIT) proto_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_FILL;
      count_q        <= '0;
      idx_q          <= '0;
      gap_q          <= '0;
      wcnt_q         <= '0;
      exp_sum_q      <= '0;
      result_q       <= '0;
      in_ready_q     <= 1'b1;
      busy_q         <= 1'b0;
      start_q        <= 1'b0;
      data_rdy_q     <= 1'b0;
      result_valid_q <= 1'b0;
      match_q        <= 1'b0;
      timeout_q      <= 1'b0;
      proto_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      idx_q          <= idx_d;
      gap_q          <= gap_d;
      wcnt_q         <= wcnt_d;
      exp_sum_q      <= exp_sum_d;
      result_q       <= result_d;
      in_ready_q     <= (state_d == ST_FILL);
      busy_q         <= (state_d inside {ST_START, ST_LEAD, ST_SEND, ST_WAIT});
      start_q        <= (state_d == ST_START);
      data_rdy_q     <= rd_en;
      result_valid_q <= result_valid_d;
      match_q        <= match_d;
      timeout_q      <= timeout_d;
      proto_q        <= proto_d;
    end
  end

  assign in_ready_o       = in_ready_q;
  assign busy_o           = busy_q;
  assign acc.acc_start    = start_q;
  assign acc.acc_data_rdy = data_rdy_q;
  assign acc.acc_indata   = rd_data;
  assign result_o         = result_q;
  assign result_valid_o   = result_valid_q;
  assign match_o          = match_q;
  assign timeout_err_o    = timeout_q;
  assign proto_err_o      = proto_q;
endmodule

// File: tb/tb_acc_feeder.sv
// tb/tb_acc_feeder.sv - scoreboard bench for acc_feeder, one instance at GAP=0 and one at GAP=2
`timescale 1ns/1ps
module tb_acc_feeder;
  localparam int WIDTH   = 32;
  localparam int LEN     = 16;
  localparam int TIMEOUT = 255;
  localparam int SW      = acc_pkg::sum_w(WIDTH, LEN);

  typedef struct packed {
    logic          to;
    logic          m;
    logic [SW-1:0] r;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             go = 1'b0;
  logic             stray = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  int               mode = 0;

  logic [1:0]       in_ready, busy, rv, match, to_err, pe, st, rdy, mdone;
  logic [SW-1:0]    result [2];
  logic [WIDTH-1:0] indata [2];
  logic [SW-1:0]    msum [2];
  logic [SW-1:0]    mout [2];
  int               mcnt [2];
  int               mdly [2];

  logic [WIDTH-1:0] words [LEN];
  logic [WIDTH-1:0] beat_q [2][$];
  exp_t             res_q [2][$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  acc_feeder_if #(.WIDTH(WIDTH), .SW(SW)) bus0 ();
  acc_feeder_if #(.WIDTH(WIDTH), .SW(SW)) bus1 ();

  acc_feeder #(.WIDTH(WIDTH), .LEN(LEN), .GAP(0), .TIMEOUT(TIMEOUT)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
    .in_data_i(in_data), .go_i(go), .busy_o(busy[0]), .acc(bus0),
    .result_o(result[0]), .result_valid_o(rv[0]), .match_o(match[0]),
    .timeout_err_o(to_err[0]), .proto_err_o(pe[0])
  );

  acc_feeder #(.WIDTH(WIDTH), .LEN(LEN), .GAP(2), .TIMEOUT(TIMEOUT)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
    .in_data_i(in_data), .go_i(go), .busy_o(busy[1]), .acc(bus1),
    .result_o(result[1]), .result_valid_o(rv[1]), .match_o(match[1]),
    .timeout_err_o(to_err[1]), .proto_err_o(pe[1])
  );

  assign st[0] = bus0.acc_start;
  assign st[1] = bus1.acc_start;
  assign rdy[0] = bus0.acc_data_rdy;
  assign rdy[1] = bus1.acc_data_rdy;
  assign indata[0] = bus0.acc_indata;
  assign indata[1] = bus1.acc_indata;
  assign bus0.acc_outdata = mout[0];
  assign bus1.acc_outdata = mout[1];
  assign bus0.acc_cal_done = mdone[0] | stray;
  assign bus1.acc_cal_done = mdone[1] | stray;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Accumulator model: mode 0 good sum, 1 sum with LSB flipped, 2 never answers.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        msum[k] <= '0; mout[k] <= '0; mcnt[k] <= 0; mdly[k] <= 0;
      end
      mdone <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        mdone[k] <= 1'b0;
        if (st[k]) begin
          msum[k] <= '0;
          mcnt[k] <= 0;
        end else if (rdy[k]) begin
          msum[k] <= msum[k] + SW'(indata[k]);
          mcnt[k] <= mcnt[k] + 1;
          if (mcnt[k] == LEN - 1) mdly[k] <= 3;
        end else if (mdly[k] != 0) begin
          mdly[k] <= mdly[k] - 1;
          if (mdly[k] == 1 && mode != 2) begin
            mdone[k] <= 1'b1;
            mout[k]  <= (mode == 1) ? (msum[k] ^ SW'(1)) : msum[k];
          end
        end
      end
    end
  end

  task automatic check(input int k, input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %0h expected %0h (cycle %0d)", k, name, act, want, cyc);
    end
  endtask

  function automatic exp_t mk(input logic to, input logic m, input logic [SW-1:0] r);
    exp_t e;
    e.to = to; e.m = m; e.r = r;
    return e;
  endfunction

  int               start_cyc [2];
  int               last_beat [2];
  int               nbeat [2];
  int               starts [2] = '{0, 0};
  logic [WIDTH-1:0] held [2];
  logic [1:0]       busy_p = '0, st_p = '0, rv_chk = '0;
  exp_t             e;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_p = '0; st_p = '0; rv_chk = '0;
      for (int k = 0; k < 2; k++) nbeat[k] = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (st[k]) begin
          check(k, "start_width", 64'(st_p[k]), 0);
          starts[k]++; start_cyc[k] = cyc; nbeat[k] = 0;
        end
        if (rdy[k]) begin
          if (beat_q[k].size() == 0) check(k, "beat_unexpected", 1, 0);
          else check(k, "beat_data", 64'(indata[k]), 64'(beat_q[k].pop_front()));
          if (nbeat[k] == 0) check(k, "first_beat_lat", 64'(cyc - start_cyc[k]), 2);
          else check(k, "beat_spacing", 64'(cyc - last_beat[k]), 64'(k * 2 + 1));
          nbeat[k]++; last_beat[k] = cyc; held[k] = indata[k];
        end else if (nbeat[k] > 0 && nbeat[k] < LEN) begin
          check(k, "gap_hold", 64'(indata[k]), 64'(held[k]));
        end
        if (busy_p[k] && !busy[k]) begin
          if (res_q[k].size() == 0) check(k, "result_unexpected", 1, 0);
          else begin
            e = res_q[k].pop_front();
            check(k, "result_valid", 64'(rv[k]), 64'(!e.to));
            check(k, "match", 64'(match[k]), 64'(e.m));
            check(k, "timeout_err", 64'(to_err[k]), 64'(e.to));
            check(k, "proto_err", 64'(pe[k]), 0);
            check(k, "in_ready_after", 64'(in_ready[k]), 1);
            check(k, "beat_count", 64'(nbeat[k]), LEN);
            if (!e.to) check(k, "result", 64'(result[k]), 64'(e.r));
            else check(k, "timeout_lat", 64'(cyc - last_beat[k]), TIMEOUT + 1);
          end
          rv_chk[k] = 1'b1;
        end else if (rv_chk[k]) begin
          check(k, "rv_width", 64'(rv[k]), 0);
          rv_chk[k] = 1'b0;
        end
        busy_p[k] = busy[k]; st_p[k] = st[k];
      end
    end
  end

  task automatic load(input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      in_valid = 1'b1; in_data = words[i];
      beat_q[0].push_back(words[i]); beat_q[1].push_back(words[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy != 2'b00 || in_ready != 2'b11) && n < 3000) begin
      @(posedge clk); n++;
    end
    #1;
    if (n >= 3000) check(0, "idle_timeout", 1, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int m, input exp_t ex);
    mode = m;
    res_q[0].push_back(ex); res_q[1].push_back(ex);
    go = 1'b1; @(posedge clk); #1; go = 1'b0;
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int s0, n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check(k, "rst_in_ready", 64'(in_ready[k]), 1);
      check(k, "rst_busy", 64'(busy[k]), 0);
      check(k, "rst_start", 64'(st[k]), 0);
      check(k, "rst_data_rdy", 64'(rdy[k]), 0);
      check(k, "rst_indata", 64'(indata[k]), 0);
      check(k, "rst_result", 64'(result[k]), 0);
      check(k, "rst_rv", 64'(rv[k]), 0);
      check(k, "rst_match", 64'(match[k]), 0);
      check(k, "rst_timeout", 64'(to_err[k]), 0);
      check(k, "rst_proto", 64'(pe[k]), 0);
      check(k, "rst_no_start", 64'(starts[k]), 0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < LEN; i++) words[i] = WIDTH'(i + 1);
    load(0, LEN);
    run_job(0, mk(1'b0, 1'b1, 36'd136));

    for (int i = 0; i < LEN; i++) words[i] = 32'hFFFF_FFFF;
    load(0, LEN);
    run_job(1, mk(1'b0, 1'b0, 36'hF_FFFF_FFF1));
    load(0, LEN);
    run_job(0, mk(1'b0, 1'b1, 36'hF_FFFF_FFF0));

    for (int i = 0; i < LEN; i++) words[i] = 32'd2;
    load(0, LEN);
    run_job(2, mk(1'b1, 1'b0, '0));
    stray = 1'b1; @(posedge clk); #1; stray = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check(k, "stray_proto", 64'(pe[k]), 1);
      check(k, "timeout_sticky", 64'(to_err[k]), 1);
      check(k, "stray_busy", 64'(busy[k]), 0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < LEN; i++) words[i] = WIDTH'(100 + i);
    load(0, 5);
    s0 = starts[0];
    go = 1'b1; @(posedge clk); #1; go = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(0, "go_in_fill_busy", 64'(busy), 0);
    check(0, "go_in_fill_start", 64'(starts[0]), 64'(s0));
    load(5, LEN);
    @(negedge clk);
    check(0, "ready_in_ready", 64'(in_ready), 0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'd999;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    check(0, "ready_no_accept", 64'(in_ready), 0);
    run_job(0, mk(1'b0, 1'b1, 36'd1720));

    for (int i = 0; i < LEN; i++) words[i] = WIDTH'(i * 5);
    load(0, LEN);
    mode = 0;
    go = 1'b1; @(posedge clk); #1; go = 1'b0;
    n = 0;
    while (nbeat[0] < 3 && n < 100) begin
      @(posedge clk); n++;
    end
    #1;
    if (n >= 100) check(0, "send_reach_timeout", 1, 0);
    rst_n = 1'b0;
    beat_q[0].delete(); beat_q[1].delete();
    res_q[0].delete(); res_q[1].delete();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check(k, "midrst_data_rdy", 64'(rdy[k]), 0);
      check(k, "midrst_busy", 64'(busy[k]), 0);
      check(k, "midrst_in_ready", 64'(in_ready[k]), 1);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < LEN; i++) words[i] = WIDTH'(i * 3);
    load(0, LEN);
    run_job(0, mk(1'b0, 1'b1, 36'd360));

    for (int k = 0; k < 2; k++) begin
      check(k, "results_pending", 64'(res_q[k].size()), 0);
      check(k, "beats_pending", 64'(beat_q[k].size()), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
